// File: rtl/sum_block_acc.sv
// rtl/sum_block_acc.sv - block accumulator for add_1p sums, valid tracked through an ADD_LAT shift line
// Optional build macro: SUM_ACC_SAT_EN (saturate the accumulator on overflow instead of wrapping).
module sum_block_acc #(
   parameter int WIDTH     = 15,
   parameter int ACC_WIDTH = 24,
   parameter int LEN_WIDTH = 8,
   parameter int ADD_LAT   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] blk_len,
   output logic                 busy,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 out_vld,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [ADD_LAT-1:0]     vl_q;
   logic [ADD_LAT-1:0]     vl_d;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   count_q;
   logic [LEN_WIDTH-1:0]   count_d;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [ACC_WIDTH-1:0]   acc_d;
   logic [ACC_WIDTH-1:0]   acc_out_q;
   logic                   out_vld_q;
   logic                   busy_q;
   logic                   ovf_q;
   logic [ACC_WIDTH:0]     add_full;
   logic                   carry;
   logic                   dv;
   logic                   last;

   // in_valid delayed by the adder latency so dv lines up with the matching sum
   always_comb begin
      vl_d    = '0;
      vl_d[0] = in_valid;
      for (int i = 1; i < ADD_LAT; i++) begin
         vl_d[i] = vl_q[i-1];
      end
   end

   assign dv       = vl_q[ADD_LAT-1];
   assign add_full = {1'b0, acc_q} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, sum};
   assign carry    = add_full[ACC_WIDTH];
   assign count_d  = count_q + LEN_WIDTH'(1);
   assign last     = (count_q == (len_q - LEN_WIDTH'(1)));

`ifdef SUM_ACC_SAT_EN
   // once clamped, any further non-zero sample carries again, so the clamp holds
   assign acc_d = carry ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
   assign acc_d = add_full[ACC_WIDTH-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vl_q      <= '0;
         len_q     <= '0;
         count_q   <= '0;
         acc_q     <= '0;
         acc_out_q <= '0;
         out_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         vl_q      <= vl_d;
         out_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ovf_q   <= 1'b0;
                  acc_q   <= '0;
                  count_q <= '0;
                  if (blk_len != '0) begin
                     len_q   <= blk_len;
                     busy_q  <= 1'b1;
                     state_q <= ST_RUN;
                  end else begin
                     acc_out_q <= '0;
                     out_vld_q <= 1'b1;
                     state_q   <= ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (dv) begin
                  acc_q   <= acc_d;
                  count_q <= count_d;
                  if (carry) begin
                     ovf_q <= 1'b1;
                  end
                  if (last) begin
                     acc_out_q <= acc_d;
                     out_vld_q <= 1'b1;
                     busy_q    <= 1'b0;
                     state_q   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign acc_out = acc_out_q;
   assign out_vld = out_vld_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_sum_block_acc.sv
// tb/tb_sum_block_acc.sv - scoreboard bench for sum_block_acc (24-bit and 16-bit accumulator instances)
module tb_sum_block_acc;
   localparam int LAT = 3;

   typedef struct {
      logic [23:0] acc;
      logic        ovf;
      int          at;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        start;
   logic [14:0] sum_src;
   logic [14:0] sum;
   logic [7:0]  blk_len;
   logic [14:0] pipe [LAT];

   logic        busy24, out_vld24, ovf24;
   logic [23:0] acc_out24;
   logic        busy16, out_vld16, ovf16;
   logic [15:0] acc_out16;

   exp_t q24[$];
   exp_t q16[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   sum_block_acc #(.WIDTH(15), .ACC_WIDTH(24), .LEN_WIDTH(8), .ADD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .start(start), .blk_len(blk_len),
      .busy(busy24), .acc_out(acc_out24), .out_vld(out_vld24), .ovf(ovf24));

   sum_block_acc #(.WIDTH(15), .ACC_WIDTH(16), .LEN_WIDTH(8), .ADD_LAT(LAT)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .start(start), .blk_len(blk_len),
      .busy(busy16), .acc_out(acc_out16), .out_vld(out_vld16), .ovf(ovf16));

   always #5 clk = ~clk;

   // stand-in for add_1p: sum appears LAT cycles after its operands
   always @(posedge clk) begin
      pipe[0] <= sum_src;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sum = pipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && out_vld24 === 1'b1) begin
         if (q24.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_vld24: got out_vld=1 expected none (cycle %0d)", cyc);
         end else begin
            e = q24.pop_front();
            chk("acc_out24", 32'(acc_out24), 32'(e.acc));
            chk("ovf24", 32'(ovf24), 32'(e.ovf));
            chk("latency24", cyc, e.at);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && out_vld16 === 1'b1) begin
         if (q16.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_vld16: got out_vld=1 expected none (cycle %0d)", cyc);
         end else begin
            e = q16.pop_front();
            chk("acc_out16", 32'(acc_out16), 32'(e.acc));
            chk("ovf16", 32'(ovf16), 32'(e.ovf));
            chk("latency16", cyc, e.at);
         end
      end
   end

   task automatic step(input logic iv, input logic [14:0] s, input logic st, input logic [7:0] len);
      in_valid = iv;
      sum_src  = s;
      start    = st;
      blk_len  = len;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 15'd0, 1'b0, 8'd0);
   endtask

   task automatic push(input logic [23:0] a24, input logic o24, input logic [23:0] a16, input logic o16, input int at);
      exp_t e;
      e.acc = a24; e.ovf = o24; e.at = at; q24.push_back(e);
      e.acc = a16; e.ovf = o16; e.at = at; q16.push_back(e);
   endtask

   initial begin
      int a;
      rst = 1'b1; in_valid = 1'b0; start = 1'b0; sum_src = '0; blk_len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy24), 32'd0);
      chk("reset_out_vld", 32'(out_vld24), 32'd0);
      chk("reset_acc_out", 32'(acc_out24), 32'd0);
      chk("reset_ovf", 32'(ovf24), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(2);

      // zero-length block
      a = cyc;
      push(24'h0, 1'b0, 24'h0, 1'b0, a + 1);
      step(1'b1, 15'd0, 1'b1, 8'd0);
      chk("len0_busy_done", 32'(busy24), 32'd0);
      idle(1);
      chk("len0_busy_idle", 32'(busy24), 32'd0);
      idle(4);

      // four back-to-back samples
      a = cyc;
      push(24'h008005, 1'b0, 24'h8005, 1'b0, a + 3 + LAT + 1);
      step(1'b1, 15'd1, 1'b1, 8'd4);
      step(1'b1, 15'd2, 1'b0, 8'd0);
      step(1'b1, 15'd3, 1'b0, 8'd0);
      chk("run_busy", 32'(busy24), 32'd1);
      step(1'b1, 15'h7FFF, 1'b0, 8'd0);
      idle(8);

      // gapped samples; two operands whose dv lands in IDLE are dropped
      step(1'b1, 15'd99, 1'b0, 8'd0);
      step(1'b1, 15'd99, 1'b0, 8'd0);
      idle(2);
      a = cyc;
      push(24'd60, 1'b0, 24'd60, 1'b0, a + 5 + LAT + 1);
      step(1'b1, 15'd10, 1'b1, 8'd3);
      idle(2);
      step(1'b1, 15'd20, 1'b0, 8'd0);
      idle(1);
      step(1'b1, 15'd30, 1'b0, 8'd0);
      idle(8);

      // overflow: 3 x 0x7FFF overflows only the 16-bit instance
      a = cyc;
`ifdef SUM_ACC_SAT_EN
      push(24'h017FFD, 1'b0, 24'hFFFF, 1'b1, a + 2 + LAT + 1);
`else
      push(24'h017FFD, 1'b0, 24'h7FFD, 1'b1, a + 2 + LAT + 1);
`endif
      step(1'b1, 15'h7FFF, 1'b1, 8'd3);
      step(1'b1, 15'h7FFF, 1'b0, 8'd0);
      step(1'b1, 15'h7FFF, 1'b0, 8'd0);
      idle(8);
      chk("ovf16_sticky", 32'(ovf16), 32'd1);

      // start pulses in RUN and DONE are ignored; the next IDLE start clears ovf
      a = cyc;
      push(24'd11, 1'b0, 24'd11, 1'b0, a + 1 + LAT + 1);
      step(1'b1, 15'd5, 1'b1, 8'd2);
      chk("ovf16_cleared", 32'(ovf16), 32'd0);
      step(1'b1, 15'd6, 1'b0, 8'd0);
      step(1'b0, 15'd0, 1'b1, 8'd0);
      idle(2);
      step(1'b0, 15'd0, 1'b1, 8'd0);
      a = cyc;
      push(24'd7, 1'b0, 24'd7, 1'b0, a + LAT + 1);
      step(1'b1, 15'd7, 1'b1, 8'd1);
      chk("fresh_block_busy", 32'(busy24), 32'd1);
      idle(8);

      // reset in the middle of a block
      step(1'b1, 15'd100, 1'b1, 8'd3);
      step(1'b1, 15'd100, 1'b0, 8'd0);
      idle(2);
      chk("pre_reset_busy", 32'(busy16), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy24), 32'd0);
      chk("midrst_out_vld", 32'(out_vld24), 32'd0);
      chk("midrst_acc_out", 32'(acc_out24), 32'd0);
      chk("midrst_ovf", 32'(ovf24), 32'd0);
      chk("midrst_busy16", 32'(busy16), 32'd0);
      chk("midrst_acc_out16", 32'(acc_out16), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      idle(8);

      chk("pending24", q24.size(), 32'd0);
      chk("pending16", q16.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
